mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Four requesters share one combinational 4x4 unsigned multiplier through a
// round-robin arbiter and an IDLE -> MUL -> RESP handshake sequencer.

module mult_share_mul4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] r0, r1, r2, r3;
  logic [7:0] s1, c1, s2, c2;
  logic [7:0] g, pr;
  logic [8:0] cy;

  // Partial-product rows reduced 4 -> 3 -> 2 by carry-save stages; the true
  // product never exceeds 225, so carries shifted out of bit 7 are always zero.
  always_comb begin
    r0 = {4'b0000, a & {4{b[0]}}};
    r1 = {4'b0000, a & {4{b[1]}}} << 1;
    r2 = {4'b0000, a & {4{b[2]}}} << 2;
    r3 = {4'b0000, a & {4{b[3]}}} << 3;
    s1 = r0 ^ r1 ^ r2;
    c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    s2 = s1 ^ c1 ^ r3;
    c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
    g  = s2 & c2;
    pr = s2 ^ c2;
    cy = '0;
    for (int i = 0; i < 8; i++) begin
      cy[i+1] = g[i] | (pr[i] & cy[i]);
    end
    p = pr ^ cy[7:0];
  end
endmodule

module mult_share_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [3:0]  req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_id,
  output logic [7:0]  resp_product,
  output logic        busy,
  output logic [7:0]  op_count
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0] op_id_q, op_id_d;
  logic [7:0] resp_product_q, resp_product_d;
  logic [1:0] resp_id_q, resp_id_d;
  logic [7:0] op_count_q, op_count_d;

  logic       grant_found;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic [7:0] mul_p;

  mult_share_mul4 u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  // Walk downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    req_ready = (state_q == IDLE && grant_found) ? (4'b0001 << grant_idx) : 4'b0000;
  end

  always_comb begin
    // NOTE: every *_d defaults to its flop so no path through the case leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_id_d        = op_id_q;
    resp_product_d = resp_product_q;
    resp_id_d      = resp_id_q;
    op_count_d     = op_count_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_a_d   = req_a[{grant_idx, 2'b00} +: 4];
          op_b_d   = req_b[{grant_idx, 2'b00} +: 4];
          op_id_d  = grant_idx;
          rr_ptr_d = grant_idx + 2'd1;
          state_d  = MUL;
        end
      end
      MUL: begin
        resp_product_d = mul_p;
        resp_id_d      = op_id_q;
        state_d        = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_id_q        <= '0;
      resp_product_q <= '0;
      resp_id_q      <= '0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_id_q        <= op_id_d;
      resp_product_q <= resp_product_d;
      resp_id_q      <= resp_id_d;
      op_count_q     <= op_count_d;
    end
  end

  assign resp_valid   = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign resp_product = resp_product_q;
  assign resp_id      = resp_id_q;
  assign op_count     = op_count_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios plus random
// traffic compared against a transaction-level round-robin/product model.

module tb_mult_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_id;
  logic [7:0]  resp_product;
  logic        busy;
  logic [7:0]  op_count;

  int checks = 0;
  int errors = 0;
  int model_rr;
  int model_count;

  mult_share_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    req_valid = 4'($urandom);
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
  endtask

  // Winner is the first valid requester met when counting up from the pointer.
  function automatic int exp_grant(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(model_rr + k) % 4]) return (model_rr + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset;
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    step;
    step;
    @(negedge clk);
    check("rst_resp_valid", 16'(resp_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_op_count", 16'(op_count), 16'd0);
    check("rst_product", 16'(resp_product), 16'd0);
    check("rst_id", 16'(resp_id), 16'd0);
    check("rst_ready", 16'(req_ready), 16'd0);
    rst = 1'b0;
    step;
    model_rr    = 0;
    model_count = 0;
  endtask

  // One full transaction starting in IDLE; hold keeps inputs steady afterwards.
  task automatic do_op(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                       input int stall, input bit hold, input string tag);
    int idx;
    int exp_p;
    req_valid  = v;
    req_a      = a;
    req_b      = b;
    resp_ready = 1'($urandom_range(0, 1));
    idx        = exp_grant(v);
    exp_p      = int'(a[4*idx +: 4]) * int'(b[4*idx +: 4]);
    @(negedge clk);
    check({tag, "_grant"}, 16'(req_ready), 16'(1 << idx));
    check({tag, "_idle_busy"}, 16'(busy), 16'd0);
    step;
    model_rr = (idx + 1) % 4;
    if (!hold) scramble;
    @(negedge clk);
    check({tag, "_mul_ready"}, 16'(req_ready), 16'd0);
    check({tag, "_mul_valid"}, 16'(resp_valid), 16'd0);
    check({tag, "_mul_busy"}, 16'(busy), 16'd1);
    step;
    for (int s = 0; s < stall; s++) begin
      resp_ready = 1'b0;
      if (!hold) scramble;
      @(negedge clk);
      check({tag, "_stall_valid"}, 16'(resp_valid), 16'd1);
      check({tag, "_stall_product"}, 16'(resp_product), 16'(exp_p));
      check({tag, "_stall_id"}, 16'(resp_id), 16'(idx));
      check({tag, "_stall_ready"}, 16'(req_ready), 16'd0);
      step;
    end
    resp_ready = 1'b1;
    if (!hold) scramble;
    @(negedge clk);
    check({tag, "_resp_valid"}, 16'(resp_valid), 16'd1);
    check({tag, "_product"}, 16'(resp_product), 16'(exp_p));
    check({tag, "_id"}, 16'(resp_id), 16'(idx));
    check({tag, "_resp_ready"}, 16'(req_ready), 16'd0);
    check({tag, "_resp_count"}, 16'(op_count), 16'(model_count));
    step;
    model_count = (model_count + 1) % 256;
    check({tag, "_done_busy"}, 16'(busy), 16'd0);
    check({tag, "_done_valid"}, 16'(resp_valid), 16'd0);
    check({tag, "_done_count"}, 16'(op_count), 16'(model_count));
  endtask

  initial begin
    logic [3:0]  v;
    logic [15:0] fa, fb;
    int          corner_a [4] = '{0, 1, 15, 8};
    int          corner_b [4] = '{13, 15, 1, 8};

    do_reset;

    // Single request, largest operands.
    do_op(4'b0001, 16'h000F, 16'h000F, 0, 1'b1, "single");

    // All requesters valid from reset: grants 0,1,2,3,0 at 3-cycle spacing.
    do_reset;
    for (int n = 0; n < 5; n++) begin
      do_op(4'b1111, 16'h4321, 16'h8765, 0, 1'b1, "rr_all");
    end

    // Idle cycles with nothing valid leave the pointer where it was.
    for (int n = 0; n < 3; n++) begin
      req_valid = '0;
      @(negedge clk);
      check("idle_ready", 16'(req_ready), 16'd0);
      check("idle_busy", 16'(busy), 16'd0);
      step;
    end

    // Backpressure for 10 cycles with all requesters still asserting.
    do_op(4'b1111, {4{4'd7}}, {4{4'd9}}, 10, 1'b1, "bp_hold");
    do_op(4'b1111, {4{4'd7}}, {4{4'd9}}, 4, 1'b0, "bp_scr");

    // Corner operands.
    for (int n = 0; n < 4; n++) begin
      fa = {4{4'(corner_a[n])}};
      fb = {4{4'(corner_b[n])}};
      do_op(4'(1 << n), fa, fb, 0, 1'b0, "corner");
    end

    // Reset while in MUL aborts the operation silently.
    do_reset;
    req_valid = 4'b0100;
    req_a     = 16'h0B00;
    req_b     = 16'h0300;
    @(negedge clk);
    check("abort_grant", 16'(req_ready), 16'b0100);
    step;
    rst       = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("abort_mul_busy", 16'(busy), 16'd1);
    step;
    rst       = 1'b0;
    req_valid = '0;
    model_rr  = 0;
    check("abort_busy", 16'(busy), 16'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("abort_no_resp", 16'(resp_valid), 16'd0);
      check("abort_count", 16'(op_count), 16'd0);
      step;
    end
    do_op(4'b1111, 16'h1234, 16'h5678, 0, 1'b0, "after_abort");

    // Exhaustive operand sweep with random requester sets, then wrap check.
    do_reset;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        v = 4'($urandom_range(1, 15));
        do_op(v, {4{4'(ia)}}, {4{4'(ib)}}, $urandom_range(0, 2), 1'b0, "sweep");
      end
    end
    check("wrap_count", 16'(op_count), 16'd0);

    // Random traffic with independent lanes.
    for (int n = 0; n < 40; n++) begin
      v = 4'($urandom_range(1, 15));
      do_op(v, 16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'b0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
